// File: rtl/sm_addsub_pkg.sv
// Shared types and helpers for the pipelined
// sign-magnitude adder/subtractor.
package sm_addsub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

    function automatic int prefix_levels(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/sm_prefix_cell.sv
// Kogge-Stone prefix node: merges a higher
// generate/propagate span with the adjacent lower one.
module sm_prefix_cell
    import sm_addsub_pkg::*;
(
    input  gp_t hi,
    input  gp_t lo,
    output gp_t o
);

    assign o = '{g: hi.g | (hi.p & lo.g), p: hi.p & lo.p};

endmodule

// File: rtl/sm_addsub_pipe.sv
// Pipelined sign-magnitude add/sub on a Kogge-Stone core
// with a collapsing valid/ready stage chain.
module sm_addsub_pipe
    import sm_addsub_pkg::*;
#(
    parameter int NUM    = 18,
    parameter int STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NUM-1:0] p,
    input  logic [NUM-1:0] q,
    input  logic           mode,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [NUM:0]   sum,
    output logic           zero,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int W  = NUM + 1;
    localparam int L  = prefix_levels(NUM);
    localparam int H  = L / 2;
    localparam int KO = STAGES - 1;

    logic [STAGES:0]   rdy;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] vup;
    logic [STAGES-1:0] ld;

    always_comb begin
        rdy = '0;
        vup = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !v[k] || rdy[k+1];
        vup[0] = in_valid;
        for (int k = 1; k < STAGES; k++)
            vup[k] = v[k-1];
        ld = rdy[STAGES-1:0] & vup;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++)
                if (rdy[k])
                    v[k] <= vup[k];
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[KO];

    logic [W-1:0] amag;
    logic [W-1:0] bmag;
    logic [W-1:0] a2c;
    logic [W-1:0] b2c;
    logic         bneg;
    gp_t  [W-1:0] gp0;
    gp_t  [W-1:0] gp1;
    gp_t  [W-1:0] gp2q;
    gp_t  [W-1:0] c2in;
    gp_t  [W-1:0] gpl;
    logic [W-1:0] p01;
    logic [W-1:0] p02;
    logic [W-1:0] s2c;
    logic [W-1:0] s3;
    logic [W-1:0] smag;

    // Subtraction is folded into the sign of B; -0 negates to 0.
    always_comb begin
        bneg = q[NUM-1];
        unique case (mode)
            MODE_ADD: bneg = q[NUM-1];
            MODE_SUB: bneg = !q[NUM-1];
        endcase
        amag = {2'b00, p[NUM-2:0]};
        bmag = {2'b00, q[NUM-2:0]};
        a2c  = p[NUM-1] ? -amag : amag;
        b2c  = bneg ? -bmag : bmag;
        gp0  = '0;
        for (int i = 0; i < W; i++) begin
            gp0[i].g = a2c[i] & b2c[i];
            gp0[i].p = a2c[i] ^ b2c[i];
        end
    end

    if (STAGES >= 2) begin : g_c1
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                gp1 <= '0;
            else if (ld[0])
                gp1 <= gp0;
        end
    end else begin : g_c1
        assign gp1 = gp0;
    end

    always_comb begin
        p01 = '0;
        for (int i = 0; i < W; i++)
            p01[i] = gp1[i].p;
    end

    for (genvar l = 0; l < L; l++) begin : g_lvl
        gp_t [W-1:0] src;
        gp_t [W-1:0] nxt;

        if (l == 0) begin : g_in
            assign src = gp1;
        end else if (l == H) begin : g_in
            assign src = gp2q;
        end else begin : g_in
            assign src = g_lvl[l-1].nxt;
        end

        for (genvar i = 0; i < W; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_node
                sm_prefix_cell u_cell (
                    .hi(src[i]),
                    .lo(src[i-(1<<l)]),
                    .o (nxt[i])
                );
            end else begin : g_pass
                assign nxt[i] = src[i];
            end
        end
    end

    assign c2in = g_lvl[H-1].nxt;
    assign gpl  = g_lvl[L-1].nxt;

    if (STAGES >= 3) begin : g_c2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gp2q <= '0;
                p02  <= '0;
            end else if (ld[1]) begin
                gp2q <= c2in;
                p02  <= p01;
            end
        end
    end else begin : g_c2
        assign gp2q = c2in;
        assign p02  = p01;
    end

    always_comb begin
        s2c    = '0;
        s2c[0] = p02[0];
        for (int i = 1; i < W; i++)
            s2c[i] = p02[i] ^ gpl[i-1].g;
    end

    if (STAGES == 4) begin : g_c3
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                s3 <= '0;
            else if (ld[2])
                s3 <= s2c;
        end
    end else begin : g_c3
        assign s3 = s2c;
    end

    // |R| < 2^NUM, so the top magnitude bit is always clear.
    assign smag = s3[W-1] ? -s3 : s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            zero <= 1'b0;
        end else if (ld[KO]) begin
            sum  <= {s3[W-1], smag[NUM-1:0]};
            zero <= (s3 == '0);
        end
    end

    logic unused_bits;
    assign unused_bits = ^{gpl, smag[W-1]};

endmodule
